axi_slave_regfile: RTL
======================

AXI_SLAVE_REGFILE -- requirements
Module: axi_slave_regfile

Interface
REQ-001 C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported.
REQ-002 C_S_AXI_ADDR_WIDTH, 32, address width.
REQ-003 aclk  in  1  single clock; all logic on rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 s_axi_awaddr  in  ADDR  write address.
REQ-006 s_axi_awvalid  in  1  write address valid.
REQ-007 s_axi_awready  out  1  write address ready.
REQ-008 s_axi_wdata  in  DATA  write data.
REQ-009 s_axi_wstrb  in  DATA/8  write byte strobes.
REQ-010 s_axi_wvalid  in  1  write data valid.
REQ-011 s_axi_wready  out  1  write data ready.
REQ-012 s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR).
REQ-013 s_axi_bvalid  out  1  write response valid.
REQ-014 s_axi_bready  in  1  write response ready.
REQ-015 s_axi_araddr  in  ADDR  read address.
REQ-016 s_axi_arvalid  in  1  read address valid.
REQ-017 s_axi_arready  out  1  read address ready.
REQ-018 s_axi_rdata  out  DATA  read data.
REQ-019 s_axi_rresp  out  2  read response (00 OKAY, 10 SLVERR).
REQ-020 s_axi_rvalid  out  1  read data valid.
REQ-021 s_axi_rready  in  1  read data ready.

Function
REQ-022 Register file: 8 x 32-bit registers REG0..REG7; index = addr[4:2]; addr[1:0] ignored.
REQ-023 Address with any bit [ADDR-1:5] set is out of range: write has no effect, responds SLVERR; read returns rdata 0, SLVERR.
REQ-024 Write FSM states: W_IDLE, W_WAIT, W_RESP.
REQ-025 W_IDLE/W_WAIT: awready=1 until AW captured, wready=1 until W captured; AW and W accepted independently, in either order or same cycle.
REQ-026 Once both captured (same cycle as the second handshake's register update): register written, per-byte by wstrb (strobe 0 keeps old byte); bvalid=1 next cycle; state W_RESP; awready=wready=0.
REQ-027 W_RESP: bvalid, bresp held stable until bvalid&&bready; then bvalid=0, return to W_IDLE, awready=wready=1 the following cycle.
REQ-028 Write latency: both handshakes in cycle N -> register updated and bvalid high at N+1.
REQ-029 Read FSM states: R_IDLE (arready=1), R_DATA (arready=0).
REQ-030 AR handshake in cycle N -> rdata/rresp/rvalid registered, visible at N+1; state R_DATA.
REQ-031 R_DATA: rdata, rresp, rvalid held stable until rvalid&&rready; then rvalid=0, R_IDLE, arready=1 next cycle.
REQ-032 Read and write FSMs independent; both may be active concurrently.
REQ-033 Read handshake in same cycle as a write commit to the same register returns the pre-write value.
REQ-034 bvalid/rvalid never depend combinationally on bready/rready; no output combinational from any input.
REQ-035 One outstanding transaction per direction; no burst support (len/size/burst not present).
REQ-036 ID, prot, cache signals absent; responses carry no EXOKAY/DECERR.

Reset
REQ-037 On aresetn=0, immediately: REG0..REG7=0, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=00, rdata=0, FSMs to W_IDLE/R_IDLE; mid-transaction state discarded.
REQ-038 First edge after aresetn deasserts: awready=wready=arready=1.

Verification
REQ-039 AW 0x08 and W 0xDEADBEEF strb F same cycle, bready=1 -> bvalid next cycle, bresp 00; read 0x08 -> rdata 0xDEADBEEF, rresp 00 one cycle after AR.
REQ-040 W (0x11223344) three cycles before AW 0x0C, then AW -> REG3=0x11223344; bready held low 5 cycles -> bvalid stays 1, awready stays 0 throughout.
REQ-041 REG1=0xFFFFFFFF, write 0x00000000 strb 0101 -> read REG1 = 0xFF00FF00.
REQ-042 Write 0x40 data 0x5 -> bresp 10, no register changed; read 0x40 -> rdata 0, rresp 10.
REQ-043 REG2=0xA, concurrent AR 0x08 and write 0xB commit same cycle -> rdata 0xA; next read 0xB; rready low 4 cycles holds rdata stable.
REQ-044 Assert aresetn=0 while bvalid pending and REG5=0x1234 -> bvalid=0, REG5=0 without clock edge; after release all readies 1.

Source files
------------

// File: rtl/axi_slave_regfile_if.sv
// ----------------------------------------------------------------------------
// axi_slave_regfile_if
// AXI4-Lite bus bundle for axi_slave_regfile. Clock and reset are not part of
// the bundle; they are plain ports on the slave.
//   AW channel : s_axi_awaddr, s_axi_awvalid (M->S), s_axi_awready (S->M)
//   W  channel : s_axi_wdata, s_axi_wstrb, s_axi_wvalid (M->S), s_axi_wready
//   B  channel : s_axi_bresp, s_axi_bvalid (S->M), s_axi_bready (M->S)
//   AR channel : s_axi_araddr, s_axi_arvalid (M->S), s_axi_arready (S->M)
//   R  channel : s_axi_rdata, s_axi_rresp, s_axi_rvalid (S->M), s_axi_rready
// ----------------------------------------------------------------------------
interface axi_slave_regfile_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                            s_axi_awvalid;
  logic                            s_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                            s_axi_wvalid;
  logic                            s_axi_wready;
  logic [1:0]                      s_axi_bresp;
  logic                            s_axi_bvalid;
  logic                            s_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
  logic                            s_axi_arvalid;
  logic                            s_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]                      s_axi_rresp;
  logic                            s_axi_rvalid;
  logic                            s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_rready
  );
endinterface

// File: rtl/axi_slave_regfile.sv
// ----------------------------------------------------------------------------
// axi_slave_regfile
// AXI4-Lite slave holding eight 32-bit registers REG0..REG7 (index addr[4:2]).
// Any address bit above bit 4 set makes the access out of range: writes are
// dropped and answered SLVERR, reads return zero with SLVERR.
// Ports:
//   aclk    - single clock, rising edge
//   aresetn - asynchronous active-low reset
//   s_axi   - AXI4-Lite bus (axi_slave_regfile_if.slave)
// All bus outputs come straight from flops; none is combinational from an
// input. Only a 32-bit data width is supported.
// ----------------------------------------------------------------------------
module axi_slave_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
) (
  input  logic               aclk,
  input  logic               aresetn,
  axi_slave_regfile_if.slave s_axi
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int SW   = DW / 8;
  localparam int NREG = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Merge new bytes over the old word where the strobe is set.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- state
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  w_state_e      w_state_q, w_state_d;
  logic          aw_got_q, aw_got_d;
  logic          w_got_q, w_got_d;
  logic [2:0]    aw_idx_q, aw_idx_d;
  logic          aw_oor_q, aw_oor_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;

  r_state_e      r_state_q, r_state_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  // ---------------------------------------------------------------- decode
  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic [2:0]    aw_idx;
  logic          aw_oor;
  logic [2:0]    ar_idx;
  logic          ar_oor;
  logic          aw_have;
  logic          w_have;
  logic [2:0]    cm_idx;
  logic          cm_oor;
  logic [DW-1:0] cm_data;
  logic [SW-1:0] cm_strb;
  logic          unused_addr_lsb;

  assign aw_hs  = s_axi.s_axi_awvalid & awready_q;
  assign w_hs   = s_axi.s_axi_wvalid & wready_q;
  assign ar_hs  = s_axi.s_axi_arvalid & arready_q;

  assign aw_idx = s_axi.s_axi_awaddr[4:2];
  assign aw_oor = |s_axi.s_axi_awaddr[AW-1:5];
  assign ar_idx = s_axi.s_axi_araddr[4:2];
  assign ar_oor = |s_axi.s_axi_araddr[AW-1:5];

  // Byte offset within a word carries no meaning here.
  assign unused_addr_lsb = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

  // "have" = already captured or being captured this cycle; the commit uses
  // the live bus value for whichever half arrives last.
  assign aw_have = aw_got_q | aw_hs;
  assign w_have  = w_got_q | w_hs;
  assign cm_idx  = aw_hs ? aw_idx : aw_idx_q;
  assign cm_oor  = aw_hs ? aw_oor : aw_oor_q;
  assign cm_data = w_hs ? s_axi.s_axi_wdata : wdata_q;
  assign cm_strb = w_hs ? s_axi.s_axi_wstrb : wstrb_q;

  // ---------------------------------------------------------------- outputs
  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = wready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;

  // Write FSM next state: capture AW/W independently, commit when both held.
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    aw_idx_d  = aw_idx_q;
    aw_oor_d  = aw_oor_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    case (w_state_q)
      W_IDLE, W_WAIT: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          aw_idx_d = aw_idx;
          aw_oor_d = aw_oor;
        end else begin
          aw_got_d = aw_got_q;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_axi.s_axi_wdata;
          wstrb_d = s_axi.s_axi_wstrb;
        end else begin
          w_got_d = w_got_q;
        end
        if (aw_have && w_have) begin
          if (!cm_oor) begin
            regs_d[cm_idx] = apply_strb(regs_q[cm_idx], cm_data, cm_strb);
            bresp_d        = RESP_OKAY;
          end else begin
            bresp_d        = RESP_SLVERR;
          end
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_RESP;
        end else begin
          // Also raises both readies on the first edge out of reset.
          awready_d = ~aw_have;
          wready_d  = ~w_have;
          w_state_d = (aw_have || w_have) ? W_WAIT : W_IDLE;
        end
      end
      W_RESP: begin
        if (s_axi.s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end else begin
          bvalid_d  = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
      end
    endcase
  end

  // Read FSM next state: regs_q is sampled before any same-cycle commit lands,
  // so a read racing a write to the same register returns the old value.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
          if (ar_oor) begin
            rdata_d = {DW{1'b0}};
            rresp_d = RESP_SLVERR;
          end else begin
            rdata_d = regs_q[ar_idx];
            rresp_d = RESP_OKAY;
          end
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi.s_axi_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end else begin
          rvalid_d  = 1'b1;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = {DW{1'b0}};
        rresp_d   = RESP_OKAY;
      end
    endcase
  end

  // State registers; reset clears the register file and all bus outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DW{1'b0}};
      end
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_idx_q  <= 3'd0;
      aw_oor_q  <= 1'b0;
      wdata_q   <= {DW{1'b0}};
      wstrb_q   <= {SW{1'b0}};
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= {DW{1'b0}};
      rresp_q   <= RESP_OKAY;
    end else begin
      regs_q    <= regs_d;
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_idx_q  <= aw_idx_d;
      aw_oor_q  <= aw_oor_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule
